// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared widths and FSM encoding for the memory access sequencer.
package mem_access_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mem_access_ctrl_reg.sv
// mem_access_ctrl_reg: parameterised enable register with async active-low clear.
module mem_access_ctrl_reg #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or negedge clear)
        if (!clear) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: ack timeout down-counter; last flags the decrement that reaches zero.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock or negedge clear)
        if (!clear) cnt <= '0;
        else if (load) cnt <= W'(TIMEOUT);
        else if (dec && cnt != '0) cnt <= cnt - W'(1);
    // A WAIT cycle with last set and no ack is the final allowed wait cycle.
    assign last = cnt == W'(1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns single-cycle read/write commands into a memory req/ack handshake
// with timeout, registered read data and an MDR load pulse.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  rd_cmd,
    input  logic                  wr_cmd,
    input  logic [ADDR_WIDTH-1:0] mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_data,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mdr_load,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);
    state_t state, next;
    logic start, last, acked, timeout, capture;
    assign start   = (state == S_IDLE) && (rd_cmd || wr_cmd);
    assign timeout = (state == S_WAIT) && !mem_ack && last;
    assign capture = (state == S_WAIT) && mem_ack && !mem_we;
    always_ff @(posedge clock or negedge clear)
        if (!clear) begin
            state <= S_IDLE;
            acked <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next;
            if (state == S_WAIT) acked <= mem_ack;
            if (timeout) err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    always_comb begin
        next     = state;
        mem_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        mdr_load = 1'b0;
        next     = (state == S_IDLE) ? (start ? S_REQ : S_IDLE)
                 : (state == S_REQ)  ? S_WAIT
                 : (state == S_WAIT) ? ((mem_ack || last) ? S_DONE : S_WAIT)
                 : S_IDLE;
        mem_req  = (state == S_REQ) || (state == S_WAIT);
        busy     = state != S_IDLE;
        done     = state == S_DONE;
        mdr_load = (state == S_DONE) && acked && !mem_we;
    end
    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clock(clock), .clear(clear),
        .load(state == S_REQ), .dec((state == S_WAIT) && !mem_ack),
        .last(last)
    );
    // Write wins when both commands arrive together, so mem_we latches wr_cmd alone.
    mem_access_ctrl_reg #(.W(ADDR_WIDTH)) u_addr (
        .clock(clock), .clear(clear), .en(start), .d(mar_addr), .q(mem_addr));
    mem_access_ctrl_reg #(.W(DATA_WIDTH)) u_wdata (
        .clock(clock), .clear(clear), .en(start), .d(mdr_data), .q(mem_wdata));
    mem_access_ctrl_reg #(.W(1)) u_we (
        .clock(clock), .clear(clear), .en(start), .d(wr_cmd), .q(mem_we));
    mem_access_ctrl_reg #(.W(DATA_WIDTH)) u_rdata (
        .clock(clock), .clear(clear), .en(capture), .d(mem_rdata), .q(Mdatain));
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed accesses checked against a transaction-level timeline model.
module tb_mem_access_ctrl;
    localparam int AW = 9, DW = 32, TO = 15;
    logic clock = 0, clear = 1, rd_cmd = 0, wr_cmd = 0, err_clr = 0, mem_ack = 0;
    logic [AW-1:0] mar_addr = '0, mem_addr;
    logic [DW-1:0] mdr_data = '0, mem_rdata = '0, mem_wdata, Mdatain;
    logic mdr_load, busy, done, err, mem_req, mem_we;
    int checks = 0, errors = 0;
    logic [DW-1:0] exp_md = '0;
    logic exp_err = 0;

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .rd_cmd(rd_cmd), .wr_cmd(wr_cmd),
        .mar_addr(mar_addr), .mdr_data(mdr_data), .Mdatain(Mdatain),
        .mdr_load(mdr_load), .busy(busy), .done(done), .err(err), .err_clr(err_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ack_at: WAIT cycle (1-based) carrying mem_ack; outside 1..TO means no ack (timeout).
    // clr_at: cycle after the command edge carrying err_clr (0 = none).
    // stray: extra ack in IDLE/REQ and a rd_cmd pulse during WAIT, all to be ignored.
    task automatic access(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rdat,
                          input int ack_at, input int clr_at, input bit stray);
        bit ok, is_wr, ack_now;
        int w;
        is_wr = wr;
        ok = ack_at >= 1 && ack_at <= TO;
        w = ok ? ack_at : TO;
        @(negedge clock);
        check("idle_busy", busy, 0);
        rd_cmd = rd; wr_cmd = wr; mar_addr = addr; mdr_data = wd;
        err_clr = 0; mem_ack = stray; mem_rdata = $urandom;
        for (int n = 1; n <= w + 4; n++) begin
            @(negedge clock);
            check("mem_req", mem_req, (n <= w + 1) ? 1 : 0);
            check("busy", busy, (n <= w + 2) ? 1 : 0);
            check("done", done, (n == w + 2) ? 1 : 0);
            check("mdr_load", mdr_load, (n == w + 2 && ok && !is_wr) ? 1 : 0);
            check("err", err, exp_err);
            check("Mdatain", Mdatain, exp_md);
            if (n <= w + 1) begin
                check("mem_addr", mem_addr, addr);
                check("mem_we", mem_we, is_wr);
                check("mem_wdata", mem_wdata, wd);
            end
            ack_now = ok && n == ack_at + 1;
            rd_cmd = stray && n == 2;
            wr_cmd = 0;
            err_clr = n == clr_at;
            mem_ack = ack_now || (stray && (n == 1 || n == w + 3));
            mem_rdata = ack_now ? rdat : $urandom;
            if (!ok && n == w + 1) exp_err = 1;
            else if (n == clr_at) exp_err = 0;
            if (ack_now && !is_wr) exp_md = rdat;
        end
    endtask

    initial begin
        #1 clear = 0;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mdr_load", mdr_load, 0);
        check("rst_err", err, 0);
        check("rst_Mdatain", Mdatain, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we", mem_we, 0);
        @(negedge clock) clear = 1;
        access(1, 0, 9'h0A5, 32'h0, 32'hDEADBEEF, 2, 0, 0);
        access(0, 1, 9'h1FF, 32'h12345678, 32'hCAFEF00D, 1, 0, 0);
        access(1, 0, 9'h033, 32'h0, 32'h11112222, 0, 0, 0);
        access(0, 1, 9'h044, 32'hA5A5A5A5, 32'h0, 2, 0, 0);
        access(1, 0, 9'h066, 32'h0, 32'h33334444, 0, TO + 1, 0);
        @(negedge clock);
        rd_cmd = 1; mar_addr = 9'h055; mem_ack = 0; err_clr = 0;
        @(negedge clock) rd_cmd = 0;
        @(negedge clock);
        #2 clear = 0;
        #1;
        exp_md = '0; exp_err = 0;
        check("arst_mem_req", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_Mdatain", Mdatain, 0);
        @(negedge clock);
        check("arst_no_done", done, 0);
        clear = 1;
        access(1, 0, 9'h077, 32'h0, 32'h5555AAAA, 4, 0, 0);
        access(1, 1, 9'h0F0, 32'h87654321, 32'h99999999, 3, 0, 1);
        access(1, 0, 9'h10F, 32'h0, 32'hFEEDFACE, TO, 0, 1);
        access(1, 0, 9'h001, 32'h0, 32'h0, TO + 1, 0, 0);
        access(0, 1, 9'h002, 32'h77777777, 32'h0, 1, 1, 0);
        for (int t = 0; t < 40; t++) begin
            int k;
            k = $urandom_range(0, 2);
            access(1'(k != 1), 1'(k != 0), AW'($urandom), $urandom, $urandom,
                   $urandom_range(0, TO + 2), $urandom_range(0, 6), 1'($urandom));
        end
        @(negedge clock);
        rd_cmd = 0; wr_cmd = 0; mem_ack = 0; err_clr = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side sequencer feeding the MDR's Mdatain input and consuming MAR address and MDR write data.
- Converts single-cycle read/write commands from the control unit into a req/ack handshake with the memory array.
- Registers returned read data, pulses MDR load, and stalls the control unit until the access completes or times out.

Parameters:
- ADDR_WIDTH, 9, memory word-address width (MAR low bits)
- DATA_WIDTH, 32, data word width
- TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
- clock  input  1  system clock, rising edge
- clear  input  1  asynchronous active-low reset
- rd_cmd  input  1  control unit: start read (one-cycle pulse)
- wr_cmd  input  1  control unit: start write (one-cycle pulse)
- mar_addr  input  ADDR_WIDTH  address from MAR
- mdr_data  input  DATA_WIDTH  write data from MDR
- Mdatain  output  DATA_WIDTH  registered read data to MDR mux
- mdr_load  output  1  one-cycle MDR enable when Mdatain is valid
- busy  output  1  access in progress; control unit stalls
- done  output  1  one-cycle completion pulse (read or write)
- err  output  1  sticky timeout flag
- err_clr  input  1  clears err
- mem_req  output  1  request to memory, held until ack
- mem_we  output  1  1 = write, held with mem_req
- mem_addr  output  ADDR_WIDTH  latched address
- mem_wdata  output  DATA_WIDTH  latched write data
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack
- mem_ack  input  1  one-cycle acknowledge

Behaviour:
- Reset (clear=0, async): state IDLE. All outputs 0, including Mdatain, err, and the timeout counter.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On rd_cmd or wr_cmd, latch mar_addr into mem_addr, mdr_data into mem_wdata, and wr_cmd into mem_we. Go to REQ.
  - If rd_cmd and wr_cmd are both 1, write wins.
  - Commands arriving while busy are ignored and not queued.
- REQ: mem_req=1 and busy=1. Load counter with TIMEOUT. Go to WAIT next cycle.
  - mem_req first asserts the cycle after the command, so minimum latency command->done is 3 cycles.
- WAIT:
  - mem_req=1. mem_addr, mem_we and mem_wdata are stable.
  - mem_ack=1: for reads, capture mem_rdata into Mdatain. Go to DONE.
  - mem_ack=0: counter decrements. If the counter reaches 0, set err=1, leave Mdatain unchanged, and go to DONE.
  - mem_ack in the same cycle as counter==0: ack wins, err is not set.
- DONE (one cycle): mem_req=0, done=1, busy=1. mdr_load=1 only for a successful read. Next state IDLE.
- busy=1 in REQ, WAIT and DONE. done and mdr_load are never asserted outside DONE.
- A mem_ack seen in IDLE or REQ is ignored.
- err is sticky. err_clr clears it; a new timeout in the same cycle as err_clr takes priority (err stays 1).
- Mdatain holds its last value between reads and is unchanged by writes.
- Reset mid-access: mem_req drops immediately (async), no done pulse, FSM to IDLE.
- mem_addr and mem_wdata remain at their last values in IDLE and are don't-care there.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams S_IDLE, S_REQ, S_WAIT, S_DONE)
  - default widths ADDR_WIDTH=9 and DATA_WIDTH=32
- Timeout counter as sub-module mem_timeout_cnt, with load/decrement/zero flag and width $clog2(TIMEOUT+1).
- Output data latches reuse the existing parameterised register module.

Test Plan:
- Read, ack after 2 WAIT cycles: rd_cmd, mar_addr=9'h0A5, mem_rdata=32'hDEADBEEF -> mem_req high for 3 cycles, Mdatain=32'hDEADBEEF, mdr_load and done pulse together, busy drops the next cycle.
- Write, ack after 1 cycle: wr_cmd, mar_addr=9'h1FF, mdr_data=32'h12345678 -> mem_we=1, mem_wdata=32'h12345678 held through ack, done=1, mdr_load=0, Mdatain unchanged.
- Timeout: rd_cmd, mem_ack never asserted, TIMEOUT=15 -> err=1 after 15 WAIT cycles, done=1, mdr_load=0. err stays set until err_clr.
- Edge-case commands: rd_cmd and wr_cmd together -> write performed. Then rd_cmd pulsed during WAIT -> ignored, exactly one access.
- Ack on the final timeout cycle: mem_ack at counter==0 -> err stays 0 and read data is captured.
- Mid-access reset: clear=0 during WAIT -> mem_req=0 asynchronously, no done. After release, a fresh read completes normally.
